sum_collector: RTL and testbench
================================

Name: sum_collector

Overview:
- Sits directly downstream of adder_tree and consumes its `sum_o`.
- adder_tree has a fixed pipeline latency and no valid or backpressure, so this block:
  - tracks which of its output cycles carry real results;
  - buffers those results in a FIFO;
  - presents them on a valid/ready stream to the correlated-randomness output path.
- It also issues a credit signal (`issue_ok_o`) upstream, so that in-flight results can never overflow the FIFO.

Parameters:
- LEN_PRNG, 256, width of one adder_tree result (matches `prng_t`).
- PIPE_LAT, 8, adder_tree latency in cycles from `ps_32_i`/`sc_32_i` input to `sum_o`.
- FIFO_DEPTH, 16, result buffer entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- issue_i  in  1  upstream drives a new vector into adder_tree this cycle.
- issue_ok_o  out  1  credit: upstream may assert `issue_i` this cycle.
- sum_i  in  LEN_PRNG  adder_tree `sum_o`.
- m_data_o  out  LEN_PRNG  head-of-FIFO result.
- m_valid_o  out  1  `m_data_o` is valid.
- m_ready_i  in  1  consumer accepts `m_data_o`.
- count_o  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- inflight_o  out  $clog2(PIPE_LAT+1)  issues still inside adder_tree.
- overflow_o  out  1  sticky: a result was dropped.
- proto_err_o  out  1  sticky: `issue_i` was asserted while `issue_ok_o`=0.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - clears the valid shift register, FIFO pointers, `count_o`, `inflight_o`, `overflow_o` and `proto_err_o`;
  - forces `m_valid_o`=0; `m_data_o` is 0 after reset.
- Reset mid-operation:
  - all pending in-flight tags are lost;
  - results emerging from adder_tree afterwards are not captured.
  - `issue_i` asserted in the reset cycle is ignored.
- Valid tracking: a PIPE_LAT-deep shift register `vpipe`.
  - `vpipe[0]` <= `issue_i` each cycle.
  - `wr_en` = `vpipe[PIPE_LAT-1]`.
  - `sum_i` is sampled in the cycle `wr_en`=1, exactly PIPE_LAT cycles after the matching `issue_i`.
- In-flight counter:
  - +1 on `issue_i`, −1 on `wr_en`, unchanged when both occur;
  - always equals popcount(`vpipe`).
- Credit:
  - `issue_ok_o` = (`count_o` + `inflight_o`) < FIFO_DEPTH, combinational from registers only.
  - `issue_i` while `issue_ok_o`=0 sets `proto_err_o`; the issue is still tracked.
- FIFO:
  - circular buffer with separate read/write pointers plus the occupancy counter.
  - First-word fall-through: `m_valid_o` = (`count_o` != 0) and `m_data_o` = mem[rd_ptr]; a newly written entry appears on the next cycle.
  - Pop when `m_valid_o` && `m_ready_i`; `rd_ptr` wraps FIFO_DEPTH-1 to 0.
  - Push when `wr_en` and (`count_o` < FIFO_DEPTH or a pop occurs this cycle); `wr_ptr` wraps FIFO_DEPTH-1 to 0.
- Simultaneous push and pop: count unchanged; allowed at full and at empty.
  - At empty, the pushed word is not popped in the same cycle because `m_valid_o` is 0.
- Overflow: `wr_en` with `count_o`=FIFO_DEPTH and no pop.
  - The result is dropped, `overflow_o` is set (sticky), and the FIFO is unchanged.
  - This is unreachable when the credit rule is honoured.
- The block never alters data: the output is a bit-exact, in-order copy of the accepted `sum_i` values.
- `m_data_o` and `m_valid_o` hold stable while `m_valid_o`=1 and `m_ready_i`=0.
- The block is independent of adder_tree's width mode; the width mode changes only the contents of the result.

Test Plan:
- Single issue: reset, then `issue_i`=1 for one cycle at t0 with `sum_i`=256'hA5..A5 driven at t0+8.
  - `m_valid_o` rises at t0+9 with `m_data_o`=A5..A5.
  - `inflight_o` reads 1 during t0+1 through t0+8, then 0.
  - `count_o` goes 1 then 0 after the pop with `m_ready_i`=1.
- Back-to-back streaming: issue every cycle for 100 cycles with `sum_i`=index, `m_ready_i`=1 constantly.
  - Outputs appear in order 0..99, no gaps after the first, `count_o` ≤ 1, no error flags.
- Credit stall: `m_ready_i`=0, upstream issues whenever `issue_ok_o`=1.
  - Exactly 16 issues are accepted.
  - `issue_ok_o` drops once count+inflight=16; after drain, `count_o`=16.
  - Then `m_ready_i`=1: 16 words in order, `count_o` returns to 0, pointers wrap, `overflow_o`=0.
- Protocol violation: with `count_o`=16 and `m_ready_i`=0, force one `issue_i`.
  - `proto_err_o`=1 next cycle; 8 cycles later `overflow_o`=1.
  - The FIFO still holds the original 16 values.
- Full with simultaneous push/pop: `count_o`=16 and `m_ready_i`=1 in the same cycle `wr_en`=1.
  - `count_o` stays 16, the new word lands at the tail, `overflow_o`=0.
- Reset mid-flight: 5 issues outstanding and 3 words buffered, then assert `rst_i` for one cycle.
  - Next cycle: `m_valid_o`=0, `count_o`=0, `inflight_o`=0, flags cleared.
  - `sum_i` arriving in the following 8 cycles is never output.

Source files
------------

// File: rtl/sum_collector.sv
// sum_collector: tags adder_tree results by issue history, buffers them in a
// first-word fall-through FIFO and presents them on a valid/ready stream.
// Issue credit keeps FIFO occupancy plus in-flight results within FIFO_DEPTH.
module sum_collector #(
  parameter int unsigned LEN_PRNG   = 256,
  parameter int unsigned PIPE_LAT   = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              issue_i,
  output logic                              issue_ok_o,
  input  logic [LEN_PRNG-1:0]               sum_i,
  output logic [LEN_PRNG-1:0]               m_data_o,
  output logic                              m_valid_o,
  input  logic                              m_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
  output logic [$clog2(PIPE_LAT+1)-1:0]     inflight_o,
  output logic                              overflow_o,
  output logic                              proto_err_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW = $clog2(PIPE_LAT + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned SW = ((CW > IW) ? CW : IW) + 1;

  logic [PIPE_LAT-1:0] vpipe;
  logic                wr_en;
  logic                pop;
  logic                push;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic [CW-1:0]       count_q;
  logic [IW-1:0]       inflight_q;
  logic [SW-1:0]       occupancy;
  logic [LEN_PRNG-1:0] mem [FIFO_DEPTH];

  assign wr_en      = vpipe[PIPE_LAT-1];
  assign m_valid_o  = (count_q != '0);
  assign m_data_o   = m_valid_o ? mem[rd_ptr] : '0;
  assign pop        = m_valid_o && m_ready_i;
  assign push       = wr_en && ((count_q < CW'(FIFO_DEPTH)) || pop);
  assign occupancy  = SW'(count_q) + SW'(inflight_q);
  assign issue_ok_o = (occupancy < SW'(FIFO_DEPTH));
  assign count_o    = count_q;
  assign inflight_o = inflight_q;

  // Valid tag shift register mirroring the adder_tree pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) vpipe <= '0;
    else       vpipe <= {vpipe[PIPE_LAT-2:0], issue_i};
  end

  // Number of issues still travelling through adder_tree.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= '0;
    end else begin
      case ({issue_i, wr_en})
        2'b10:   inflight_q <= inflight_q + IW'(1);
        2'b01:   inflight_q <= inflight_q - IW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Result storage; contents need no reset since validity comes from count.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem[wr_ptr] <= sum_i;
  end

  // Sticky error flags: dropped result and issue without credit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o  <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      if (wr_en && !push)         overflow_o  <= 1'b1;
      if (issue_i && !issue_ok_o) proto_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sum_collector.sv
// Scoreboard bench for sum_collector with a delay-line model of adder_tree.
module tb_sum_collector;

  localparam int unsigned LEN   = 256;
  localparam int unsigned LAT   = 8;
  localparam int unsigned DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           issue = 1'b0;
  logic [LEN-1:0] issue_data = '0;
  logic           issue_ok;
  logic [LEN-1:0] sum;
  logic [LEN-1:0] m_data;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [4:0]     count;
  logic [3:0]     inflight;
  logic           overflow;
  logic           proto_err;

  logic [LEN-1:0] at_pipe [LAT];
  logic [LEN-1:0] exp_q [$];
  int             errors = 0;
  int             checks = 0;

  always #5 clk = ~clk;

  sum_collector #(.LEN_PRNG(LEN), .PIPE_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .issue_i(issue), .issue_ok_o(issue_ok),
    .sum_i(sum), .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .count_o(count), .inflight_o(inflight), .overflow_o(overflow),
    .proto_err_o(proto_err)
  );

  // adder_tree stand-in: data issued in cycle t is on sum in cycle t+LAT.
  always @(posedge clk) begin
    at_pipe[0] <= issue_data;
    for (int i = 1; i < LAT; i++) at_pipe[i] <= at_pipe[i-1];
  end
  assign sum = at_pipe[LAT-1];

  // Monitor: compare every accepted output word against the scoreboard.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected got=%h", m_data);
      end else begin
        logic [LEN-1:0] e;
        e = exp_q.pop_front();
        if (m_data !== e) begin
          errors++;
          $display("FAIL out_data got=%h exp=%h", m_data, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [LEN-1:0] act, input logic [LEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_valid"}, LEN'(m_valid), 1'b0);
    chk({name, "_count"}, LEN'(count), '0);
    chk({name, "_inflight"}, LEN'(inflight), '0);
    chk({name, "_overflow"}, LEN'(overflow), 1'b0);
    chk({name, "_proto"}, LEN'(proto_err), 1'b0);
  endtask

  // Issue whenever credit allows, with ready low, for a fixed window.
  task automatic fill(input logic [31:0] base, output int accepted);
    accepted = 0;
    m_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      issue = issue_ok;
      issue_data = LEN'(base + 32'(accepted));
      if (issue_ok) begin
        exp_q.push_back(LEN'(base + 32'(accepted)));
        accepted++;
      end
      step();
    end
    issue = 1'b0;
  endtask

  task automatic drain(input string name);
    int c;
    m_ready = 1'b1;
    c = 0;
    while (count != 0 && c < 40) begin
      step();
      c++;
    end
    chk({name, "_drained"}, LEN'(count), '0);
    m_ready = 1'b0;
  endtask

  initial begin
    int acc;
    step();
    step();
    rst = 1'b0;
    // Reset state
    check_idle("reset");
    chk("reset_data", m_data, '0);
    chk("reset_issue_ok", LEN'(issue_ok), 1'b1);

    // Single issue
    m_ready = 1'b1;
    issue = 1'b1;
    issue_data = {32{8'hA5}};
    exp_q.push_back({32{8'hA5}});
    step();
    issue = 1'b0;
    issue_data = '0;
    for (int k = 1; k <= LAT; k++) begin
      chk("single_inflight", LEN'(inflight), 1);
      chk("single_valid_low", LEN'(m_valid), 1'b0);
      step();
    end
    chk("single_inflight_done", LEN'(inflight), 0);
    chk("single_valid", LEN'(m_valid), 1'b1);
    chk("single_count1", LEN'(count), 1);
    step();
    chk("single_count0", LEN'(count), 0);
    chk("single_valid_drop", LEN'(m_valid), 1'b0);

    // Back-to-back streaming: outputs cycles LAT+1 .. LAT+100 without gaps
    for (int c = 0; c < 112; c++) begin
      issue = (c < 100);
      issue_data = LEN'(c);
      if (c < 100) exp_q.push_back(LEN'(c));
      chk("stream_valid", LEN'(m_valid), LEN'((c >= LAT + 1) && (c <= LAT + 100)));
      chk("stream_count_le1", LEN'(count <= 5'd1), 1'b1);
      step();
    end
    issue = 1'b0;
    chk("stream_overflow", LEN'(overflow), 1'b0);
    chk("stream_proto", LEN'(proto_err), 1'b0);

    // Credit stall and drain
    fill(32'hC000, acc);
    chk("stall_accepted", LEN'(acc), 16);
    chk("stall_count", LEN'(count), 16);
    chk("stall_inflight", LEN'(inflight), 0);
    chk("stall_issue_ok", LEN'(issue_ok), 1'b0);
    drain("stall");
    chk("stall_overflow", LEN'(overflow), 1'b0);
    chk("stall_proto", LEN'(proto_err), 1'b0);

    // Protocol violation at full: forced result is dropped
    fill(32'hD000, acc);
    chk("viol_count_pre", LEN'(count), 16);
    issue = 1'b1;
    issue_data = LEN'(32'hBAD0);
    step();
    issue = 1'b0;
    chk("viol_proto", LEN'(proto_err), 1'b1);
    chk("viol_overflow_early", LEN'(overflow), 1'b0);
    for (int k = 0; k < LAT - 1; k++) step();
    chk("viol_overflow_pre", LEN'(overflow), 1'b0);
    step();
    chk("viol_overflow", LEN'(overflow), 1'b1);
    chk("viol_count", LEN'(count), 16);
    drain("viol");

    // Full with simultaneous push and pop
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    check_idle("rst2");
    fill(32'hE000, acc);
    issue = 1'b1;
    issue_data = LEN'(32'hF00D);
    exp_q.push_back(LEN'(32'hF00D));
    step();
    issue = 1'b0;
    for (int k = 0; k < LAT - 1; k++) step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("fullpp_count", LEN'(count), 16);
    chk("fullpp_overflow", LEN'(overflow), 1'b0);
    chk("fullpp_proto", LEN'(proto_err), 1'b1);
    drain("fullpp");

    // Reset mid-flight: 3 buffered, 5 outstanding
    for (int c = 0; c < 11; c++) begin
      issue = (c < 8);
      issue_data = LEN'(32'h3100 + 32'(c));
      step();
    end
    chk("mid_count", LEN'(count), 3);
    chk("mid_inflight", LEN'(inflight), 5);
    rst = 1'b1;
    issue = 1'b1;
    issue_data = LEN'(32'h3900);
    exp_q.delete();
    step();
    rst = 1'b0;
    issue = 1'b0;
    check_idle("mid_rst");
    m_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      chk("mid_no_output", LEN'(m_valid), 1'b0);
      step();
    end
    m_ready = 1'b0;

    chk("scoreboard_empty", LEN'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
